// File: rtl/freq_sweep_tracker.sv
// freq_sweep_tracker: steps the SWIPT drive frequency from start_freq to stop_freq in coarse
// steps. It can then run a fine pass around the best coarse point. At each point it waits
// SETTLE_CYC cycles, averages 2^AVG_LOG2 ADC magnitudes and keeps the peak.
// Ports:
//   clk, nrst          clock, asynchronous active-low reset
//   swipt_alive        link up; low aborts and clears results
//   go                 level start; low aborts / acknowledges done
//   adc                unsigned ADC sample, valid every cycle
//   start_freq, stop_freq, coarse_step, fine_step, refine_en   sweep config, latched at start
//   new_freq           frequency to apply to the oscillator
//   best_freq/best_mag peak frequency and its averaged magnitude
//   busy, done         sweep in progress / complete (done held until go falls)
module freq_sweep_tracker #(
  parameter int unsigned FREQ_W     = 20,
  parameter int unsigned ADC_W      = 12,
  parameter int unsigned SETTLE_CYC = 200000,
  parameter int unsigned AVG_LOG2   = 4
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              swipt_alive,
  input  logic              go,
  input  logic [ADC_W-1:0]  adc,
  input  logic [FREQ_W-1:0] start_freq,
  input  logic [FREQ_W-1:0] stop_freq,
  input  logic [FREQ_W-1:0] coarse_step,
  input  logic [FREQ_W-1:0] fine_step,
  input  logic              refine_en,
  output logic [FREQ_W-1:0] new_freq,
  output logic [FREQ_W-1:0] best_freq,
  output logic [ADC_W-1:0]  best_mag,
  output logic              busy,
  output logic              done
);

  localparam int unsigned NumAvg = 1 << AVG_LOG2;
  localparam int unsigned AccW   = ADC_W + AVG_LOG2;
  localparam int unsigned CntMax = (SETTLE_CYC > NumAvg) ? SETTLE_CYC : NumAvg;
  localparam int unsigned CntW   = $clog2(CntMax) + 1;

  typedef enum logic [2:0] {
    StIdle, StSettle, StMeasure, StEval, StFineSetup, StDone
  } state_e;

  state_e            state_q, state_d;
  logic [FREQ_W-1:0] new_freq_q, new_freq_d;
  logic [FREQ_W-1:0] best_freq_q, best_freq_d;
  logic [ADC_W-1:0]  best_mag_q, best_mag_d;
  logic [FREQ_W-1:0] start_q, start_d;
  logic [FREQ_W-1:0] stop_q, stop_d;
  logic [FREQ_W-1:0] step_q, step_d;
  logic [FREQ_W-1:0] coarse_q, coarse_d;
  logic [FREQ_W-1:0] fine_q, fine_d;
  logic              refine_q, refine_d;
  logic              fine_pass_q, fine_pass_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [AccW-1:0]   acc_q, acc_d;

  logic [ADC_W-1:0]  mag;
  logic [ADC_W-1:0]  avg;
  logic [FREQ_W:0]   nxt;
  logic [FREQ_W:0]   lo_sub;
  logic [FREQ_W:0]   hi_sum;
  logic [FREQ_W-1:0] lo_raw, fine_lo, fine_hi;
  logic [FREQ_W-1:0] best_freq_new;

  // Distance to the nearest rail; (2^ADC_W-1)-adc is just the bitwise inverse.
  assign mag = adc[ADC_W-1] ? ~adc : adc;
  assign avg = acc_q[AccW-1:AVG_LOG2];

  // One extra bit so a step past the top of the range cannot wrap back into it.
  assign nxt    = {1'b0, new_freq_q} + {1'b0, step_q};
  assign lo_sub = {1'b0, best_freq_q} - {1'b0, coarse_q};
  assign hi_sum = {1'b0, best_freq_q} + {1'b0, coarse_q};
  assign lo_raw  = lo_sub[FREQ_W] ? '0 : lo_sub[FREQ_W-1:0];
  assign fine_lo = (lo_raw < start_q) ? start_q : lo_raw;
  assign fine_hi = (hi_sum > {1'b0, stop_q}) ? stop_q : hi_sum[FREQ_W-1:0];

  always_comb begin
    state_d       = state_q;
    new_freq_d    = new_freq_q;
    best_freq_d   = best_freq_q;
    best_mag_d    = best_mag_q;
    start_d       = start_q;
    stop_d        = stop_q;
    step_d        = step_q;
    coarse_d      = coarse_q;
    fine_d        = fine_q;
    refine_d      = refine_q;
    fine_pass_d   = fine_pass_q;
    cnt_d         = cnt_q;
    acc_d         = acc_q;
    best_freq_new = best_freq_q;

    if (!swipt_alive) begin
      state_d     = StIdle;
      best_mag_d  = '0;
      best_freq_d = start_freq;
    end else if (state_q != StIdle && !go) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          new_freq_d = start_freq;
          if (go) begin
            start_d     = start_freq;
            stop_d      = stop_freq;
            step_d      = coarse_step;
            coarse_d    = coarse_step;
            fine_d      = fine_step;
            refine_d    = refine_en;
            fine_pass_d = 1'b0;
            best_mag_d  = '0;
            best_freq_d = start_freq;
            cnt_d       = '0;
            state_d     = StSettle;
          end
        end
        StSettle: begin
          if (cnt_q == CntW'(SETTLE_CYC - 1)) begin
            cnt_d   = '0;
            acc_d   = '0;
            state_d = StMeasure;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StMeasure: begin
          acc_d = acc_q + AccW'(mag);
          if (cnt_q == CntW'(NumAvg - 1)) begin
            cnt_d   = '0;
            state_d = StEval;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StEval: begin
          // Strict compare: on a tie the earlier (lower) frequency wins.
          if (avg > best_mag_q) begin
            best_mag_d    = avg;
            best_freq_d   = new_freq_q;
            best_freq_new = new_freq_q;
          end
          if (nxt <= {1'b0, stop_q} && step_q != '0) begin
            new_freq_d = nxt[FREQ_W-1:0];
            state_d    = StSettle;
          end else if (!fine_pass_q && refine_q) begin
            state_d = StFineSetup;
          end else begin
            new_freq_d = best_freq_new;
            state_d    = StDone;
          end
        end
        StFineSetup: begin
          new_freq_d  = fine_lo;
          stop_d      = fine_hi;
          step_d      = fine_q;
          fine_pass_d = 1'b1;
          cnt_d       = '0;
          state_d     = StSettle;
        end
        StDone: begin
          new_freq_d = best_freq_q;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= StIdle;
      new_freq_q  <= '0;
      best_freq_q <= '0;
      best_mag_q  <= '0;
      start_q     <= '0;
      stop_q      <= '0;
      step_q      <= '0;
      coarse_q    <= '0;
      fine_q      <= '0;
      refine_q    <= 1'b0;
      fine_pass_q <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
    end else begin
      state_q     <= state_d;
      new_freq_q  <= new_freq_d;
      best_freq_q <= best_freq_d;
      best_mag_q  <= best_mag_d;
      start_q     <= start_d;
      stop_q      <= stop_d;
      step_q      <= step_d;
      coarse_q    <= coarse_d;
      fine_q      <= fine_d;
      refine_q    <= refine_d;
      fine_pass_q <= fine_pass_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
    end
  end

  assign new_freq  = new_freq_q;
  assign best_freq = best_freq_q;
  assign best_mag  = best_mag_q;
  assign busy      = (state_q == StSettle) || (state_q == StMeasure) ||
                     (state_q == StEval) || (state_q == StFineSetup);
  assign done      = (state_q == StDone);

endmodule
